// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode constants and IR field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT,
    ST_STOPPED
  } state_e;

  localparam logic [4:0] INC_OP        = 5'd12;
  localparam logic [4:0] MUL_OP        = 5'd15;
  localparam logic [4:0] DIV_OP        = 5'd16;
  localparam logic [4:0] HALT_OP       = 5'd27;
  localparam logic [4:0] MAX_PLAIN_OP  = 5'd11;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

endpackage

// File: rtl/reg_select_encode.sv
// Converts a 4-bit register field into a one-hot 16-bit enable, gated by en.
module reg_select_encode (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving the datapath strobes from the
// registered step state and the IR opcode/register fields.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [4:0] INC_OP  = cpu_pkg::INC_OP,
  parameter logic [4:0] MUL_OP  = cpu_pkg::MUL_OP,
  parameter logic [4:0] DIV_OP  = cpu_pkg::DIV_OP,
  parameter logic [4:0] HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic [4:0]  OpCode,
  output logic [15:0] Rin,
  output logic [15:0] Rout
);

  state_e state, next;

  logic [4:0] op;
  logic [3:0] ra, rb, rc, rout_sel;
  logic       rin_en, rout_en, is_muldiv, is_plain;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign is_muldiv = (op == MUL_OP) || (op == DIV_OP);
  assign is_plain  = (op <= MAX_PLAIN_OP) || is_muldiv;

  always_ff @(posedge clk) begin
    if (clr) state <= ST_RESET;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    Run      = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    OpCode   = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    unique case (state)
      ST_RESET: next = ST_T0;
      ST_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = INC_OP;
        next = ST_T1;
      end
      ST_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next = ST_T2;
      end
      ST_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        next = ST_T3;
      end
      ST_T3: begin
        Run = 1'b1; rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
        // Halt is checked first so a HALT_OP override inside 0..11 still halts.
        if (op == HALT_OP)  next = ST_HALT;
        else if (is_plain)  next = ST_T4;
        else                next = ST_T0;
      end
      ST_T4: begin
        Run = 1'b1; rout_en = 1'b1; rout_sel = rc; Zin = 1'b1; OpCode = op;
        next = ST_T5;
      end
      ST_T5: begin
        Run = 1'b1; Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
          next = ST_T6;
        end else begin
          rin_en = 1'b1;
          next   = Stop ? ST_STOPPED : ST_T0;
        end
      end
      ST_T6: begin
        Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
        next = Stop ? ST_STOPPED : ST_T0;
      end
      ST_HALT:    next = ST_HALT;
      ST_STOPPED: next = Stop ? ST_STOPPED : ST_T0;
      default:    next = ST_RESET;
    endcase
  end

  reg_select_encode u_rin_enc (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_select_encode u_rout_enc (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  a_single_bus_driver: assert property (@(posedge clk)
    $onehot0({PCout, Zlowout, Zhighout, MDRout, |Rout}) && $onehot0(Rout) && $onehot0(Rin));

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: each row drives one cycle of inputs
// and queues the outputs expected after the following rising edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        Stop = 1'b0;
  logic [31:0] IR = '0;
  logic        Run, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin;
  logic        MDRin, IRin, Yin, HIin, LOin, Read;
  logic [4:0]  OpCode;
  logic [15:0] Rin, Rout;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .Read(Read),
    .OpCode(OpCode), .Rin(Rin), .Rout(Rout)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] F_RUN = 14'h2000, F_PCO = 14'h1000, F_ZLO = 14'h0800,
                          F_ZHI = 14'h0400, F_MDO = 14'h0200, F_MAR = 14'h0100,
                          F_ZIN = 14'h0080, F_PCI = 14'h0040, F_MDI = 14'h0020,
                          F_IRI = 14'h0010, F_YIN = 14'h0008, F_HII = 14'h0004,
                          F_LOI = 14'h0002, F_RD  = 14'h0001;
  localparam logic [13:0] S_T0 = F_RUN | F_PCO | F_MAR | F_ZIN;
  localparam logic [13:0] S_T1 = F_RUN | F_ZLO | F_PCI | F_RD | F_MDI;
  localparam logic [13:0] S_T2 = F_RUN | F_MDO | F_IRI;
  localparam logic [13:0] S_T3 = F_RUN | F_YIN;
  localparam logic [13:0] S_T4 = F_RUN | F_ZIN;

  typedef struct {
    string       tag;
    logic        clr;
    logic        stop;
    logic [31:0] ir;
    logic [50:0] exp;
  } vec_t;

  typedef struct {
    string       tag;
    logic [50:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  function automatic logic [50:0] ex(input logic [13:0] f, input logic [4:0] op,
                                     input logic [15:0] rin, input logic [15:0] rout);
    return {f, op, rin, rout};
  endfunction

  task automatic add(input string tag, input logic c, input logic s, input logic [31:0] ir,
                     input logic [50:0] e);
    vec_t v;
    v.tag = tag; v.clr = c; v.stop = s; v.ir = ir; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    sb_t e;
    @(negedge clk);
    clr = v.clr; Stop = v.stop; IR = v.ir;
    e.tag = v.tag; e.exp = v.exp;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      sb_t e;
      logic [50:0] act;
      e = sb.pop_front();
      act = {Run, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
             Yin, HIin, LOin, Read, OpCode, Rin, Rout};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] i_and, i_mul, i_div, i_nop, i_hlt;
    logic [50:0] z, t0, t1, t2;
    vec_t hv;
    i_and = 32'h28918000;
    i_mul = mk_ir(5'd15, 4'd4, 4'd5, 4'd6);
    i_div = mk_ir(5'd16, 4'd7, 4'd8, 4'd9);
    i_nop = mk_ir(5'd20, 4'd1, 4'd2, 4'd3);
    i_hlt = mk_ir(5'd27, 4'd1, 4'd2, 4'd3);
    z  = '0;
    t0 = ex(S_T0, 5'd12, 16'h0, 16'h0);
    t1 = ex(S_T1, 5'd0, 16'h0, 16'h0);
    t2 = ex(S_T2, 5'd0, 16'h0, 16'h0);

    add("rst1", 1, 0, i_and, z);
    add("rst2", 1, 0, i_and, z);
    add("and_t0", 0, 0, i_and, t0);
    add("and_t1", 0, 0, i_and, t1);
    add("and_t2", 0, 0, i_and, t2);
    add("and_t3", 0, 0, i_and, ex(S_T3, 5'd0, 16'h0, 16'h0004));
    add("and_t4", 0, 0, i_and, ex(S_T4, 5'd5, 16'h0, 16'h0008));
    add("and_t5", 0, 0, i_and, ex(F_RUN | F_ZLO, 5'd0, 16'h0002, 16'h0));
    add("and_next_t0", 0, 0, i_and, t0);

    add("mul_t1", 0, 0, i_mul, t1);
    add("mul_t2", 0, 0, i_mul, t2);
    add("mul_t3", 0, 0, i_mul, ex(S_T3, 5'd0, 16'h0, 16'h0020));
    add("mul_t4", 0, 0, i_mul, ex(S_T4, 5'd15, 16'h0, 16'h0040));
    add("mul_t5", 0, 0, i_mul, ex(F_RUN | F_ZLO | F_LOI, 5'd0, 16'h0, 16'h0));
    add("mul_t6", 0, 0, i_mul, ex(F_RUN | F_ZHI | F_HII, 5'd0, 16'h0, 16'h0));
    add("mul_next_t0", 0, 0, i_mul, t0);

    add("div_t1", 0, 0, i_div, t1);
    add("div_t2", 0, 0, i_div, t2);
    add("div_t3", 0, 0, i_div, ex(S_T3, 5'd0, 16'h0, 16'h0100));
    add("div_t4", 0, 0, i_div, ex(S_T4, 5'd16, 16'h0, 16'h0200));
    add("div_t5", 0, 0, i_div, ex(F_RUN | F_ZLO | F_LOI, 5'd0, 16'h0, 16'h0));
    add("div_t6", 0, 0, i_div, ex(F_RUN | F_ZHI | F_HII, 5'd0, 16'h0, 16'h0));
    add("div_stop_t6", 0, 1, i_div, z);
    add("div_resume", 0, 0, i_div, t0);

    add("nop_t1", 0, 0, i_nop, t1);
    add("nop_t2", 0, 0, i_nop, t2);
    add("nop_t3", 0, 0, i_nop, ex(S_T3, 5'd0, 16'h0, 16'h0004));
    add("nop_next_t0", 0, 0, i_nop, t0);

    add("stp_t1", 0, 0, i_and, t1);
    add("stp_t2", 0, 0, i_and, t2);
    add("stp_t3", 0, 1, i_and, ex(S_T3, 5'd0, 16'h0, 16'h0004));
    add("stp_t4", 0, 1, i_and, ex(S_T4, 5'd5, 16'h0, 16'h0008));
    add("stp_t5", 0, 1, i_and, ex(F_RUN | F_ZLO, 5'd0, 16'h0002, 16'h0));
    add("stp_stopped1", 0, 1, i_and, z);
    add("stp_stopped2", 0, 1, i_and, z);
    add("stp_resume", 0, 0, i_and, t0);

    add("mid_t1", 0, 0, i_and, t1);
    add("mid_t2", 0, 0, i_and, t2);
    add("mid_t3", 0, 0, i_and, ex(S_T3, 5'd0, 16'h0, 16'h0004));
    add("mid_t4", 0, 0, i_and, ex(S_T4, 5'd5, 16'h0, 16'h0008));
    add("mid_clr", 1, 0, i_and, z);
    add("mid_t0", 0, 0, i_and, t0);
    add("mid_t1b", 0, 0, i_and, t1);

    add("cs_t2", 0, 0, i_and, t2);
    add("cs_t3", 0, 0, i_and, ex(S_T3, 5'd0, 16'h0, 16'h0004));
    add("cs_t4", 0, 0, i_and, ex(S_T4, 5'd5, 16'h0, 16'h0008));
    add("cs_t5", 0, 0, i_and, ex(F_RUN | F_ZLO, 5'd0, 16'h0002, 16'h0));
    add("cs_clr_stop", 1, 1, i_and, z);
    add("cs_t0", 0, 0, i_and, t0);

    add("hlt_t1", 0, 0, i_hlt, t1);
    add("hlt_t2", 0, 0, i_hlt, t2);
    add("hlt_t3", 0, 0, i_hlt, ex(S_T3, 5'd0, 16'h0, 16'h0004));

    foreach (vecs[i]) drive(vecs[i]);

    hv.tag = "halt_hold"; hv.clr = 0; hv.stop = 0; hv.ir = i_hlt; hv.exp = z;
    for (int k = 0; k < 20; k++) drive(hv);
    hv.tag = "halt_clr"; hv.clr = 1;
    drive(hv);
    hv.tag = "halt_restart_t0"; hv.clr = 0; hv.exp = t0;
    drive(hv);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the existing datapath's strobe inputs, replacing hand-sequenced testbench stimulus. It runs the fetch/execute step sequence T0–T6. It decodes the IR opcode and register fields, and emits one-hot register enables plus the datapath control strobes. It sits directly upstream of the datapath: outputs connect 1:1 to the datapath control ports, and the only input from the datapath is `IR`.

## Interface
- `INC_OP`, default 5'd12: ALU code for PC increment in T0.
- `MUL_OP`, default 5'd15: opcode needing the HI/LO writeback sequence.
- `DIV_OP`, default 5'd16: opcode needing the HI/LO writeback sequence.
- `HALT_OP`, default 5'd27: halt opcode.
- `clk` in 1: rising-edge clock shared with the datapath.
- `clr` in 1: reset; one clock, synchronous, active-high.
- `IR` in 32: datapath instruction register. Fields: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- `Stop` in 1: request to pause at the next instruction boundary.
- `Run` out 1: high while executing; low in reset, halt and stop.
- `PCout, Zlowout, Zhighout, MDRout` out 1 each: bus drivers.
- `MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Read` out 1 each: load strobes.
- `OpCode` out 5: ALU operation select.
- `Rin` out 16: one-hot general-register load enables (R0in..R15in).
- `Rout` out 16: one-hot general-register bus drivers (R0out..R15out).

## Operation
- Moore FSM. Outputs are a pure function of the registered state and `IR`.
- Each strobe is held for the whole state cycle. The datapath captures on the rising edge that ends the state.
- States and transitions: RESET→T0→T1→T2→T3→T4→T5, then T5→T0, or T5→T6→T0 for mul/div. HALT and STOPPED are additional terminal/pause states.
- Per-state strobe assertions:
  - RESET: all outputs 0, `Run`=0.
  - T0: `PCout`, `MARin`, `Zin`; `OpCode`=`INC_OP`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
  - T3: Rout[Rb], `Yin`.
  - T4: Rout[Rc], `Zin`; `OpCode`=IR[31:27].
  - T5, normal op: `Zlowout`, Rin[Ra]; next T0.
  - T5, mul/div: `Zlowout`, `LOin`; next T6.
  - T6: `Zhighout`, `HIin`; next T0.
- Decode in T3 uses the IR value loaded at the end of T2.
- Opcode 5'd0–5'd11 and mul/div: normal execution as above.
- `HALT_OP`: T3 goes to HALT. No further strobes; `Run`=0. Only `clr` exits HALT.
- Any other opcode: T3→T0 (no-op). No register or Z write occurs.
- `Stop` is sampled only in T5/T6 on the edge that would enter T0. If high, go to STOPPED with all strobes 0 and `Run`=0. STOPPED returns to T0 on the first cycle `Stop` is low.
- In states without a register select, `Rin`/`Rout` are all zero. Neither bus is ever multi-hot.
- At most one bus driver is asserted in any state. This is checked by an assertion.

## Timing
- `clr` high at a rising edge forces RESET on that edge, from any state including mid-instruction. The partially executed instruction is abandoned with no further strobes.
- Reset values: `Run`=0, every strobe 0, `OpCode`=0, `Rin`=`Rout`=0.
- The first T0 is the cycle after `clr` is released.
- Instruction latency:
  - Normal ops: 6 cycles, T0–T5.
  - mul/div: 7 cycles.
  - Unsupported opcode: 4 cycles.
- Destination register update is visible one cycle after T5; the next T0 starts that same cycle.
- `Stop` asserted mid-instruction does not shorten the instruction.
- `clr` and `Stop` high together: `clr` wins.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum;
  - opcode constants (`INC_OP`, `MUL_OP`, `DIV_OP`, `HALT_OP`, ALU op codes);
  - IR field bit-position localparams.
- One sub-module, `reg_select_encode`: 4-bit field plus enable → 16-bit one-hot. Instantiated twice, once for `Rin` and once for `Rout`; mux field selection stays in the parent.
- The FSM stays in `control_sequencer`.

## Test plan
- Reset: `clr` high for 2 cycles from an arbitrary state → all outputs 0, `Run`=0. T0 strobes (`PCout`, `MARin`, `Zin`, `OpCode`=12) appear the cycle after release.
- "and R1,R2,R3": IR=32'h28918000 loaded at end of T2 → Rout=16'h0004+`Yin` in T3; Rout=16'h0008, `OpCode`=5, `Zin` in T4; `Zlowout`, Rin=16'h0002 in T5; then T0.
- mul: IR op=15 → T5 `Zlowout`+`LOin` with Rin=0; T6 `Zhighout`+`HIin`; 7-cycle instruction.
- Halt: IR op=27 → after T3, all strobes 0 and `Run`=0 for 20 cycles. `clr` restarts from T0.
- Stop: `Stop` raised in T2 → instruction completes through T5, then STOPPED. Dropping `Stop` gives T0 the next cycle.
- Mid-instruction reset: `clr` asserted during T4 → `Zin`/`Rout` drop on that edge, Ra never written, next T0 proceeds normally.
